sign_extend_pipe: RTL and testbench

//  Parametrised, registered sign/zero extender with valid/ready handshake and a
//  2-entry skid buffer. Widens an IN_W-bit immediate/field to OUT_W bits in one of

---
 rtl/sign_extend_pipe.sv | 114 +++++++++++
 tb/tb_sign_extend_pipe.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sign_extend_pipe.sv
// rtl/sign_extend_pipe.sv - registered sign/zero extender with valid/ready handshake and 2-entry skid buffer
// Main register M drives the outputs; skid register S absorbs one beat while downstream stalls.
module sign_extend_pipe #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  data_in,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] data_out,
   output logic             out_err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [OUT_W-1:0] m_data_q, m_data_d;
   logic [OUT_W-1:0] s_data_q, s_data_d;
   logic             m_err_q, m_err_d;
   logic             s_err_q, s_err_d;
   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] ext_data;
   logic             ext_err;
   logic             accept;
   logic             xfer;

   always_comb begin
      sext     = {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};
      ext_data = '0;
      ext_err  = 1'b0;
      case (mode)
         2'b00:   ext_data = {{(OUT_W-IN_W){1'b0}}, data_in};
         2'b01:   ext_data = sext;
         2'b10:   ext_data = {sext[OUT_W-2:0], 1'b0};
         default: ext_err  = 1'b1;
      endcase
   end

   // in_ready comes straight from the state register, so it never sees out_ready.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign data_out  = m_data_q;
   assign out_err   = m_err_q;
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;

   always_comb begin
      state_d  = state_q;
      m_data_d = m_data_q;
      m_err_d  = m_err_q;
      s_data_d = s_data_q;
      s_err_d  = s_err_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  m_data_d = ext_data;
                  m_err_d  = ext_err;
                  state_d  = ONE;
               end
            end
            ONE: begin
               if (accept && xfer) begin
                  m_data_d = ext_data;
                  m_err_d  = ext_err;
               end else if (xfer) begin
                  state_d = EMPTY;
               end else if (accept) begin
                  s_data_d = ext_data;
                  s_err_d  = ext_err;
                  state_d  = FULL;
               end
            end
            FULL: begin
               if (xfer) begin
                  m_data_d = s_data_q;
                  m_err_d  = s_err_q;
                  state_d  = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= EMPTY;
         m_data_q <= '0;
         m_err_q  <= 1'b0;
         s_data_q <= '0;
         s_err_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_data_q <= m_data_d;
         m_err_q  <= m_err_d;
         s_data_q <= s_data_d;
         s_err_q  <= s_err_d;
      end
   end

endmodule

// File: tb/tb_sign_extend_pipe.sv
// tb/tb_sign_extend_pipe.sv - directed and scoreboard bench for sign_extend_pipe
module tb_sign_extend_pipe;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] data_in;
   logic [1:0] mode;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] data_out;
   logic       out_err;

   int checks   = 0;
   int failures = 0;

   sign_extend_pipe #(.IN_W(3), .OUT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] model(input logic [2:0] d, input logic [1:0] m);
      logic [7:0] s;
      s = d[2] ? (8'hF8 | {5'd0, d}) : {5'd0, d};
      case (m)
         2'd0:    model = {1'b0, 5'd0, d};
         2'd1:    model = {1'b0, s};
         2'd2:    model = {1'b0, s[6:0], 1'b0};
         default: model = {1'b1, 8'h00};
      endcase
   endfunction

   logic [8:0] sb[$];
   logic [8:0] exp_beat;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; data_in = '0; mode = '0; out_ready = 1'b0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_data_out", data_out, 0);
      chk("rst_out_err", out_err, 0);
      rst_n = 1'b1;
      tick();

      // 1: three modes back to back
      out_ready = 1'b1; in_valid = 1'b1; data_in = 3'b101; mode = 2'b00;
      tick();
      chk("t1_valid0", out_valid, 1);
      chk("t1_zext", data_out, 8'h05);
      mode = 2'b01;
      tick();
      chk("t1_sext", data_out, 8'hFD);
      mode = 2'b10;
      tick();
      chk("t1_shl", data_out, 8'hFA);
      in_valid = 1'b0;
      tick();
      chk("t1_idle_valid", out_valid, 0);
      chk("t1_idle_hold", data_out, 8'hFA);

      // 2: backpressure fills the skid register
      in_valid = 1'b1; data_in = 3'b011; mode = 2'b01;
      tick();
      chk("t2_first", data_out, 8'h03);
      out_ready = 1'b0; data_in = 3'b100;
      tick();
      chk("t2_full_ready", in_ready, 0);
      chk("t2_stall_data", data_out, 8'h03);
      data_in = 3'b111;
      tick();
      chk("t2_still_full", in_ready, 0);
      chk("t2_stable", data_out, 8'h03);
      out_ready = 1'b1;
      tick();
      chk("t2_second", data_out, 8'hFC);
      chk("t2_ready_back", in_ready, 1);
      tick();
      chk("t2_third", data_out, 8'hFF);
      in_valid = 1'b0;
      tick();
      chk("t2_drained", out_valid, 0);

      // 3: illegal mode flows with err flag
      in_valid = 1'b1; data_in = 3'b010; mode = 2'b11;
      tick();
      chk("t3_valid", out_valid, 1);
      chk("t3_data", data_out, 8'h00);
      chk("t3_err", out_err, 1);
      mode = 2'b01;
      tick();
      chk("t3_next_data", data_out, 8'h02);
      chk("t3_next_err", out_err, 0);
      in_valid = 1'b0;
      tick();

      // 4: flush from FULL
      out_ready = 1'b0; in_valid = 1'b1; data_in = 3'b001; mode = 2'b00;
      tick();
      data_in = 3'b010;
      tick();
      chk("t4_full", in_ready, 0);
      flush = 1'b1; data_in = 3'b011;
      tick();
      chk("t4_flush_valid", out_valid, 0);
      chk("t4_flush_ready", in_ready, 1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("t4_no_ghost", out_valid, 0);
      in_valid = 1'b1; data_in = 3'b110; mode = 2'b00;
      tick();
      chk("t4_after_data", data_out, 8'h06);
      in_valid = 1'b0;
      tick();

      // 5: asynchronous reset between edges
      in_valid = 1'b1; data_in = 3'b101; mode = 2'b01;
      tick();
      chk("t5_pre", data_out, 8'hFD);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_async_valid", out_valid, 0);
      chk("t5_async_data", data_out, 0);
      chk("t5_async_err", out_err, 0);
      in_valid = 1'b0;
      #4 rst_n = 1'b1;
      tick();
      chk("t5_ready", in_ready, 1);
      chk("t5_valid", out_valid, 0);

      // 6: random traffic against a scoreboard
      for (int cyc = 0; cyc < 4000; cyc++) begin
         in_valid  = ($urandom_range(0, 99) < 60);
         out_ready = ($urandom_range(0, 99) < 60);
         data_in   = 3'($urandom_range(0, 7));
         mode      = 2'($urandom_range(0, 3));
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("t6_spurious", 1, 0);
            end else begin
               exp_beat = sb.pop_front();
               chk("t6_beat", {out_err, data_out}, exp_beat);
            end
         end
         if (in_valid && in_ready) sb.push_back(model(data_in, mode));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 10 && sb.size() != 0; i++) begin
         @(negedge clk);
         if (out_valid) begin
            exp_beat = sb.pop_front();
            chk("t6_drain", {out_err, data_out}, exp_beat);
         end
         @(posedge clk);
         #1;
      end
      chk("t6_sb_empty", sb.size(), 0);
      chk("t6_final_valid", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
